// File: rtl/hs_txn_profiler.sv
// Per-transaction start/latency/stall profiler for an ap_ctrl_hs module.
// Define HS_PROFILER_STALL_EN to keep the stall counter and its FIFO column.
module hs_txn_profiler #(
  parameter int TS_W  = 32,
  parameter int LAT_W = 24,
  parameter int DEPTH = 8
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   ap_start,
  input  logic                   ap_ready,
  input  logic                   ap_done,
  input  logic                   ap_continue,
  input  logic                   stall,
  input  logic                   clear,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [TS_W-1:0]        rec_ts,
  output logic [LAT_W-1:0]       rec_lat,
  output logic [LAT_W-1:0]       rec_stall,
  output logic                   rec_sat,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            drop_cnt,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [LAT_W-1:0] LMAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t          state;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_q;
  logic [LAT_W-1:0] lat;
  logic [LAT_W-1:0] stl;
  logic            sat;

  logic            stl_in;
  logic            unused_ok;

  logic            lat_ovf;
  logic            stl_ovf;
  logic [LAT_W-1:0] lat_nx;
  logic [LAT_W-1:0] stl_nx;

  logic            push;
  logic [TS_W-1:0] p_ts;
  logic [LAT_W-1:0] p_lat;
  logic [LAT_W-1:0] p_stl;
  logic            p_sat;

`ifdef HS_PROFILER_STALL_EN
  assign stl_in    = stall;
  assign unused_ok = ap_ready;
`else
  assign stl_in    = 1'b0;
  assign unused_ok = ^{ap_ready, stall, p_stl};
`endif

  assign lat_ovf = (lat == LMAX);
  assign lat_nx  = lat_ovf ? lat : lat + LAT_W'(1);
  assign stl_ovf = stl_in && (stl == LMAX);
  assign stl_nx  = stl + LAT_W'(stl_in && !stl_ovf);

  // Record that would be pushed this cycle, counting the current cycle.
  always_comb begin
    push  = 1'b0;
    p_ts  = ts;
    p_lat = LAT_W'(1);
    p_stl = LAT_W'(stl_in);
    p_sat = 1'b0;
    unique case (state)
      IDLE: push = ap_start && ap_done && ap_continue;
      RUN: begin
        push  = ap_done && ap_continue;
        p_ts  = ts_q;
        p_lat = lat_nx;
        p_stl = stl_nx;
        p_sat = sat || lat_ovf || stl_ovf;
      end
      HOLD: begin
        push  = ap_continue;
        p_ts  = ts_q;
        p_lat = lat;
        p_stl = stl;
        p_sat = sat;
      end
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      ts    <= '0;
      ts_q  <= '0;
      lat   <= '0;
      stl   <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      ts    <= '0;
      ts_q  <= '0;
      lat   <= '0;
      stl   <= '0;
      sat   <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            ts_q <= ts;
            lat  <= LAT_W'(1);
            stl  <= LAT_W'(stl_in);
            sat  <= 1'b0;
            if (ap_done && ap_continue) state <= IDLE;
            else if (ap_done)           state <= HOLD;
            else                        state <= RUN;
          end
        end
        RUN: begin
          lat <= lat_nx;
          stl <= stl_nx;
          sat <= p_sat;
          if (ap_done) state <= ap_continue ? IDLE : HOLD;
        end
        HOLD: begin
          if (ap_continue) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    level;
  logic [AW-1:0]    rd_idx;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  logic [TS_W-1:0]  mem_ts  [DEPTH];
  logic [LAT_W-1:0] mem_lat [DEPTH];
  logic [DEPTH-1:0] mem_sat;

  assign level  = wr_ptr - rd_ptr;
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (level == '0);
  assign full   = (level == PW'(DEPTH));
  assign pop    = !empty && rec_ready;
  assign wr_en  = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      mem_ts[wr_ptr[AW-1:0]]  <= p_ts;
      mem_lat[wr_ptr[AW-1:0]] <= p_lat;
      mem_sat[wr_ptr[AW-1:0]] <= p_sat;
    end
  end

`ifdef HS_PROFILER_STALL_EN
  logic [LAT_W-1:0] mem_stl [DEPTH];

  always_ff @(posedge ap_clk) begin
    if (wr_en) mem_stl[wr_ptr[AW-1:0]] <= p_stl;
  end

  assign rec_stall = empty ? '0 : mem_stl[rd_idx];
`else
  assign rec_stall = '0;
`endif

  // Head fields read as zero while empty so reset values are defined.
  assign rec_valid  = !empty;
  assign rec_ts     = empty ? '0 : mem_ts[rd_idx];
  assign rec_lat    = empty ? '0 : mem_lat[rd_idx];
  assign rec_sat    = !empty && mem_sat[rd_idx];
  assign fifo_level = level;

endmodule

// File: tb/tb_hs_txn_profiler.sv
// Directed bench for hs_txn_profiler; a second instance with
// LAT_W=4 shares the stimulus to observe saturation.
module tb_hs_txn_profiler;

`ifdef HS_PROFILER_STALL_EN
  localparam int STALL_ON = 1;
`else
  localparam int STALL_ON = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hs_ready;
  logic        done;
  logic        cont;
  logic        stall;
  logic        clear;
  logic        ready;

  logic        valid;
  logic [31:0] r_ts;
  logic [23:0] r_lat;
  logic [23:0] r_stl;
  logic        r_sat;
  logic [3:0]  level;
  logic [15:0] drops;
  logic        busy;

  logic        s_valid;
  logic [31:0] s_ts;
  logic [3:0]  s_lat;
  logic [3:0]  s_stl;
  logic        s_sat;
  logic [3:0]  s_level;
  logic [15:0] s_drops;
  logic        s_busy;

  int vectors;
  int miscompares;
  int tb_ts;

  hs_txn_profiler dut (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .ap_start    (start),
    .ap_ready    (hs_ready),
    .ap_done     (done),
    .ap_continue (cont),
    .stall       (stall),
    .clear       (clear),
    .rec_valid   (valid),
    .rec_ready   (ready),
    .rec_ts      (r_ts),
    .rec_lat     (r_lat),
    .rec_stall   (r_stl),
    .rec_sat     (r_sat),
    .fifo_level  (level),
    .drop_cnt    (drops),
    .busy        (busy)
  );

  hs_txn_profiler #(.LAT_W(4)) dut_s (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .ap_start    (start),
    .ap_ready    (hs_ready),
    .ap_done     (done),
    .ap_continue (cont),
    .stall       (stall),
    .clear       (clear),
    .rec_valid   (s_valid),
    .rec_ready   (ready),
    .rec_ts      (s_ts),
    .rec_lat     (s_lat),
    .rec_stall   (s_stl),
    .rec_sat     (s_sat),
    .fifo_level  (s_level),
    .drop_cnt    (s_drops),
    .busy        (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tb_ts++;
  endtask

  task automatic wait_to(input int t);
    while (tb_ts < t) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tb_ts = 0;
  endtask

  task automatic pop_one();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 64'(valid), 64'd0);
    chk({tag, ".ts"},    64'(r_ts),  64'd0);
    chk({tag, ".lat"},   64'(r_lat), 64'd0);
    chk({tag, ".stall"}, 64'(r_stl), 64'd0);
    chk({tag, ".sat"},   64'(r_sat), 64'd0);
    chk({tag, ".level"}, 64'(level), 64'd0);
    chk({tag, ".drop"},  64'(drops), 64'd0);
    chk({tag, ".busy"},  64'(busy),  64'd0);
  endtask

  initial begin
    int exp_q [8];
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 10};
    vectors     = 0;
    miscompares = 0;
    tb_ts       = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    hs_ready = 1'b0;
    done     = 1'b0;
    cont     = 1'b1;
    stall    = 1'b0;
    clear    = 1'b0;
    ready    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    tb_ts = 0;

    // single transaction: start 5, done 14, stall 7..9
    wait_to(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(7);
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_to(14);
    chk("t1.busy_run", 64'(busy), 64'd1);
    chk("t1.valid_pre", 64'(valid), 64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t1.valid", 64'(valid), 64'd1);
    chk("t1.ts", 64'(r_ts), 64'd5);
    chk("t1.lat", 64'(r_lat), 64'd10);
    chk("t1.stall", 64'(r_stl), 64'(STALL_ON ? 3 : 0));
    chk("t1.level", 64'(level), 64'd1);
    chk("t1.busy_end", 64'(busy), 64'd0);
    pop_one();
    chk("t1.popped", 64'(valid), 64'd0);

    // same-cycle start/done, then back-to-back restart
    do_clear();
    wait_to(3);
    start = 1'b1;
    done  = 1'b1;
    tick();
    done = 1'b0;
    chk("t2.lat1", 64'(r_lat), 64'd1);
    chk("t2.ts3", 64'(r_ts), 64'd3);
    chk("t2.busy_idle", 64'(busy), 64'd0);
    pop_one();
    chk("t2.busy_b", 64'(busy), 64'd1);
    wait_to(10);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t2.b_ts", 64'(r_ts), 64'd4);
    chk("t2.b_lat", 64'(r_lat), 64'd7);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    chk("t2.c_busy", 64'(busy), 64'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t2.c_ts", 64'(r_ts), 64'd11);
    chk("t2.c_lat", 64'(r_lat), 64'd2);
    pop_one();

    // HOLD: done at 20, continue low until 25
    wait_to(18);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(20);
    done = 1'b1;
    cont = 1'b0;
    tick();
    done = 1'b0;
    chk("t3.hold_busy", 64'(busy), 64'd1);
    chk("t3.hold_valid", 64'(valid), 64'd0);
    wait_to(25);
    chk("t3.busy25", 64'(busy), 64'd1);
    chk("t3.valid25", 64'(valid), 64'd0);
    cont = 1'b1;
    tick();
    chk("t3.valid", 64'(valid), 64'd1);
    chk("t3.ts", 64'(r_ts), 64'd18);
    chk("t3.lat", 64'(r_lat), 64'd3);
    chk("t3.busy_end", 64'(busy), 64'd0);
    pop_one();

    // overflow: ten pushes into eight entries, then push+pop when full
    do_clear();
    start = 1'b1;
    done  = 1'b1;
    repeat (10) tick();
    chk("t4.level", 64'(level), 64'd8);
    chk("t4.drop", 64'(drops), 64'd2);
    chk("t4.head0", 64'(r_ts), 64'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    done  = 1'b0;
    chk("t4.level11", 64'(level), 64'd8);
    chk("t4.drop11", 64'(drops), 64'd2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4.drain%0d", i), 64'(r_ts), 64'(exp_q[i]));
      pop_one();
    end
    chk("t4.empty", 64'(valid), 64'd0);

    // clear mid-RUN with three records queued
    start = 1'b1;
    done  = 1'b1;
    repeat (3) tick();
    done = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("t6.pre_level", 64'(level), 64'd3);
    chk("t6.pre_busy", 64'(busy), 64'd1);
    chk("t6.pre_drop", 64'(drops), 64'd2);
    do_clear();
    chk("t6.level", 64'(level), 64'd0);
    chk("t6.busy", 64'(busy), 64'd0);
    chk("t6.drop", 64'(drops), 64'd0);
    chk("t6.valid", 64'(valid), 64'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t6.no_rec", 64'(valid), 64'd0);

    // saturation: 20-cycle transaction, LAT_W=4 instance clamps
    do_clear();
    wait_to(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(21);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t5.lat_wide", 64'(r_lat), 64'd20);
    chk("t5.sat_wide", 64'(r_sat), 64'd0);
    chk("t5.lat_sat", 64'(s_lat), 64'd15);
    chk("t5.sat", 64'(s_sat), 64'd1);
    chk("t5.ts_sat", 64'(s_ts), 64'd2);

    // async reset mid-RUN with a record still queued
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t7.busy", 64'(busy), 64'd1);
    chk("t7.level", 64'(level), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("t7.rst");
    chk("t7.s_valid", 64'(s_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tb_ts = 0;
    done  = 1'b1;
    tick();
    done = 1'b0;
    chk("t7.no_rec", 64'(valid), 64'd0);
    chk("t7.busy_after", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hs_txn_profiler.md
# hs_txn_profiler

Synthesizable per-module transaction profiler that sits directly downstream of one `ap_ctrl_hs` sub-module of `sobel_hls`, such as a `sobel_hls_Pipeline_*` loop instance. It consumes that module's start/ready/done/continue handshake and a stall qualifier, and measures each transaction's start timestamp, latency and stall cycles. It buffers the results as records in a small FIFO and presents them on a valid/ready record stream, which feeds the status dump path in place of simulation-only CSV sampling.

## Interface
Parameters:
- `TS_W`, 32: width of the free-running timestamp and of `rec_ts`.
- `LAT_W`, 24: width of the latency and stall counters.
- `DEPTH`, 8: number of record FIFO entries; must be a power of 2, minimum 2.

Ports:
- `ap_clk`  in  1: the single clock; all logic is rising-edge.
- `ap_rst_n`  in  1: asynchronous, active-low reset.
- `ap_start`  in  1: observed module's `ap_start`.
- `ap_ready`  in  1: observed module's `ap_ready`; informational only.
- `ap_done`  in  1: observed module's `ap_done`.
- `ap_continue`  in  1: observed module's `ap_continue`; tie to 1 if unused.
- `stall`  in  1: the module's `ap_block_pp0_stage0_subdone` or `ap_ST_fsm_state1_blk`.
- `clear`  in  1: synchronous flush.
- `rec_valid`  out  1: a record is available at the FIFO head.
- `rec_ready`  in  1: the consumer accepts the head record.
- `rec_ts`  out  TS_W: timestamp of the transaction's start cycle.
- `rec_lat`  out  LAT_W: transaction latency in cycles.
- `rec_stall`  out  LAT_W: number of stalled cycles in the transaction.
- `rec_sat`  out  1: latency or stall counter saturated during the transaction.
- `fifo_level`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `drop_cnt`  out  16: count of records dropped because the FIFO was full.
- `busy`  out  1: FSM is not in IDLE.

## Operation
- **Timestamp.** `ts` is a TS_W-bit counter that increments every cycle and wraps modulo 2^TS_W.
- **FSM states:** IDLE, RUN, HOLD.
- **IDLE:**
  - If `ap_start`=1: latch `ts` and load `lat`=1 and `stl`=`stall`.
  - If `ap_done`&`ap_continue` are also high in the same cycle: push the record immediately and stay in IDLE.
  - Else if `ap_done`=1 (so `ap_continue`=0): go to HOLD.
  - Otherwise: go to RUN.
- **RUN:**
  - Every cycle: `lat`+=1, and `stl`+=`stall`.
  - On `ap_done`: the done cycle is counted.
  - On `ap_done` with `ap_continue`=1: push the record and go to IDLE.
  - On `ap_done` with `ap_continue`=0: go to HOLD.
- **HOLD:** counters are frozen. When `ap_continue`=1, push the record and go to IDLE.
- **Back-to-back transactions:** if `ap_start` is still high in the cycle after a push, IDLE starts the next transaction. This matches the HLS restart behaviour.
- **Saturation:** `lat` and `stl` saturate at 2^LAT_W−1; on saturation the transaction's `sat` bit is set.
- **Record FIFO:**
  - First-word-fall-through; `rec_*` show the head entry and `rec_valid`=!empty.
  - A pop occurs on `rec_valid`&`rec_ready`.
  - Push when full with no pop in the same cycle: the record is dropped and `drop_cnt` increments, saturating at 0xFFFF.
  - Push and pop in the same cycle when full: both succeed.
  - Push and pop in the same cycle when empty: the pop is not possible (`rec_valid`=0), so the push is written.
  - Read and write pointers are $clog2(DEPTH)+1 bits and wrap naturally.
- **`clear`** has priority over everything. In the same edge it resets `ts`, the FSM to IDLE, the counters, the FIFO pointers and `drop_cnt`. A transaction that is in flight is discarded.
- **`ap_ready`** does not affect the FSM.

## Timing
- **Reset values** (asynchronous, on `ap_rst_n`=0): `rec_valid`=0, `rec_ts`/`rec_lat`/`rec_stall`=0, `rec_sat`=0, `fifo_level`=0, `drop_cnt`=0, `busy`=0, `ts`=0, FSM=IDLE.
- **Reset deassertion:** takes effect on the first rising edge after `ap_rst_n` rises. `ts`=0 in the first active cycle.
- **Latency definition:** cycles from the start cycle to the done cycle, inclusive of both. A transaction with start and done in the same cycle has latency 1.
- **Record visibility:** `rec_valid` rises the cycle after the push cycle. `fifo_level` updates in the same cycle as `rec_valid`.
- **`busy`:** 1 in the cycle after start acceptance through the push cycle, inclusive.
- **Reset mid-transaction:** all state is lost and no partial record is emitted.

## Configuration
- **`HS_PROFILER_STALL_EN` defined:** the stall counter is present and `rec_stall` carries the counted stall cycles.
- **`HS_PROFILER_STALL_EN` undefined:** the `stall` input is ignored, `rec_stall` is constant 0, and stall storage is removed from the FIFO. `rec_sat` then reflects latency saturation only.

## Test plan
- **Single transaction:** reset, then `ap_start` at ts=5 and `ap_done` at ts=14 with `ap_continue`=1 and `stall` high for 3 cycles. Required: one record with `rec_ts`=5, `rec_lat`=10, `rec_stall`=3, and `rec_valid` rising at ts=15.
- **Same-cycle start and done:** start and done both high at ts=3. Required: record `rec_lat`=1. Then hold start high through done at ts=10. Required: the next transaction starts at ts=11.
- **HOLD:** done at ts=20 with `ap_continue`=0 until ts=25. Required: `rec_lat` excludes the HOLD cycles, the push happens at ts=25, and `busy`=1 through ts=25.
- **FIFO overflow:** DEPTH=8 with `rec_ready`=0 and 10 transactions. Required: `fifo_level`=8 and `drop_cnt`=2. Then assert `rec_ready` in the same cycle as the 11th push. Required: the 11th push is accepted and `drop_cnt` stays 2.
- **Saturation:** LAT_W=4 and a 20-cycle transaction. Required: `rec_lat`=15 and `rec_sat`=1.
- **Clear and reset mid-run:** `clear` pulse mid-RUN with 3 records queued. Required: the next cycle shows `fifo_level`=0, `busy`=0 and `drop_cnt`=0. Also pulse `ap_rst_n` low mid-RUN. Required: all outputs return to their reset values and no record is emitted.
